// File: rtl/riscv_writeback_pkg.sv
// Shared definitions for the RV32I writeback stage: datapath width, result-source
// codes, load funct3 codes and the load alignment rule.
package riscv_writeback_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Unlisted funct3 codes behave as LW, so they need word alignment.
   function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      case (funct3)
         F3_LB, F3_LBU: mis = 1'b0;
         F3_LH, F3_LHU: mis = offset[0];
         default:       mis = (offset != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/riscv_writeback_if.sv
// MEM-stage handshake, data-memory response and regfile write port of the
// writeback stage. The slave modport is the writeback stage itself.
interface riscv_writeback_if #(parameter int XLEN = 32);

   logic            i_wb_valid;
   logic            o_wb_ready;
   logic [1:0]      i_wb_sel;
   logic [4:0]      i_wb_rd_addr;
   logic            i_wb_rd_wen;
   logic [2:0]      i_wb_funct3;
   logic [XLEN-1:0] i_wb_alu_result;
   logic [XLEN-1:0] i_wb_pc_plus4;
   logic            i_dmem_rvalid;
   logic [XLEN-1:0] i_dmem_rdata;
   logic [XLEN-1:0] o_regfile_rd_data;
   logic [4:0]      o_regfile_rd_addr;
   logic            o_regfile_rd_wen;
   logic            o_wb_misalign;

   modport master (
      output i_wb_valid, i_wb_sel, i_wb_rd_addr, i_wb_rd_wen, i_wb_funct3,
             i_wb_alu_result, i_wb_pc_plus4, i_dmem_rvalid, i_dmem_rdata,
      input  o_wb_ready, o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen,
             o_wb_misalign
   );

   modport slave (
      input  i_wb_valid, i_wb_sel, i_wb_rd_addr, i_wb_rd_wen, i_wb_funct3,
             i_wb_alu_result, i_wb_pc_plus4, i_dmem_rvalid, i_dmem_rdata,
      output o_wb_ready, o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen,
             o_wb_misalign
   );

endinterface

// File: rtl/riscv_load_align.sv
// Combinational load lane select and sign/zero extension of a 32-bit memory word.
module riscv_load_align #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);
   import riscv_writeback_pkg::*;

   logic [XLEN-1:0] shifted_s;
   logic [7:0]      byte_s;
   logic [15:0]     half_s;

   // Pick the addressed byte/halfword lane, then extend according to funct3.
   always_comb begin
      shifted_s = rdata >> {offset, 3'b000};
      byte_s    = shifted_s[7:0];
      half_s    = shifted_s[15:0];
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_writeback.sv
// RV32I writeback stage: selects ALU / load / PC+4 result and drives the regfile
// write port. Optional retire counter enabled by RISCV_WB_RETIRE_CNT_EN.
module riscv_writeback #(
   parameter int XLEN = 32
`ifdef RISCV_WB_RETIRE_CNT_EN
   , parameter int CNT_W = 64
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   riscv_writeback_if.slave   wb
`ifdef RISCV_WB_RETIRE_CNT_EN
   , output logic [CNT_W-1:0] o_wb_retire_cnt
`endif
);
   import riscv_writeback_pkg::*;

   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

   logic [0:0]      state_r;
   logic            ready_r;
   logic [XLEN-1:0] rd_data_r;
   logic [4:0]      rd_addr_r;
   logic            rd_wen_r;
   logic            misalign_r;
   logic [4:0]      cap_addr_r;
   logic            cap_wen_r;
   logic [2:0]      cap_funct3_r;
   logic [1:0]      cap_offset_r;

   logic            accept_s;
   logic            is_load_s;
   logic            misaligned_s;
   logic [XLEN-1:0] direct_result_s;
   logic [XLEN-1:0] load_result_s;

   riscv_load_align #(.XLEN(XLEN)) u_load_align (
      .rdata  (wb.i_dmem_rdata),
      .offset (cap_offset_r),
      .funct3 (cap_funct3_r),
      .result (load_result_s)
   );

   // Accept decode and non-load result mux; reserved select code falls back to ALU.
   always_comb begin
      accept_s     = wb.i_wb_valid & ready_r;
      is_load_s    = (wb.i_wb_sel == WB_SEL_LOAD);
      misaligned_s = load_misaligned(wb.i_wb_funct3, wb.i_wb_alu_result[1:0]);
      if (wb.i_wb_sel == WB_SEL_PC4) begin
         direct_result_s = wb.i_wb_pc_plus4;
      end else begin
         direct_result_s = wb.i_wb_alu_result;
      end
   end

   // FSM, captured load context and registered regfile outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         ready_r      <= 1'b1;
         rd_data_r    <= {XLEN{1'b0}};
         rd_addr_r    <= 5'd0;
         rd_wen_r     <= 1'b0;
         misalign_r   <= 1'b0;
         cap_addr_r   <= 5'd0;
         cap_wen_r    <= 1'b0;
         cap_funct3_r <= 3'd0;
         cap_offset_r <= 2'd0;
      end else begin
         rd_wen_r   <= 1'b0;
         misalign_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (!is_load_s) begin
                     rd_data_r <= direct_result_s;
                     rd_addr_r <= wb.i_wb_rd_addr;
                     rd_wen_r  <= wb.i_wb_rd_wen & (wb.i_wb_rd_addr != 5'd0);
                  end else if (misaligned_s) begin
                     misalign_r <= 1'b1;
                  end else begin
                     cap_addr_r   <= wb.i_wb_rd_addr;
                     cap_wen_r    <= wb.i_wb_rd_wen;
                     cap_funct3_r <= wb.i_wb_funct3;
                     cap_offset_r <= wb.i_wb_alu_result[1:0];
                     state_r      <= ST_LOAD_WAIT;
                     ready_r      <= 1'b0;
                  end
               end
            end
            ST_LOAD_WAIT: begin
               if (wb.i_dmem_rvalid) begin
                  rd_data_r <= load_result_s;
                  rd_addr_r <= cap_addr_r;
                  rd_wen_r  <= cap_wen_r & (cap_addr_r != 5'd0);
                  state_r   <= ST_IDLE;
                  ready_r   <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

`ifdef RISCV_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_cnt_r;
   logic             retire_s;

   // A retirement is a non-load accept, a misaligned load, or a load response.
   always_comb begin
      if (state_r == ST_IDLE) begin
         retire_s = accept_s & (!is_load_s | misaligned_s);
      end else begin
         retire_s = wb.i_dmem_rvalid;
      end
   end

   // Free-running retire counter, wraps naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         retire_cnt_r <= {CNT_W{1'b0}};
      end else if (retire_s) begin
         retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_wb_retire_cnt = retire_cnt_r;
`endif

   assign wb.o_wb_ready        = ready_r;
   assign wb.o_regfile_rd_data = rd_data_r;
   assign wb.o_regfile_rd_addr = rd_addr_r;
   assign wb.o_regfile_rd_wen  = rd_wen_r;
   assign wb.o_wb_misalign     = misalign_r;

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed, scoreboarded bench for riscv_writeback: expected regfile writes are
// queued when stimulus is driven and checked whenever the stage writes.
module tb_riscv_writeback;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   riscv_writeback_if #(.XLEN(32)) bus ();

`ifdef RISCV_WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt;
`endif

   riscv_writeback #(.XLEN(32)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .wb    (bus)
`ifdef RISCV_WB_RETIRE_CNT_EN
      , .o_wb_retire_cnt (retire_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [36:0] exp_q[$];   // {rd_addr, rd_data}

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Scoreboard: every write pulse must match the oldest queued expectation.
   always @(negedge i_clk) begin
      if (!i_rst && bus.o_regfile_rd_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", {27'd0, bus.o_regfile_rd_addr}, 32'hDEAD_0000);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("sb_addr", {27'd0, bus.o_regfile_rd_addr}, {27'd0, e[36:32]});
            check("sb_data", bus.o_regfile_rd_data, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
      bus.i_wb_valid      = 1'b1;
      bus.i_wb_sel        = sel;
      bus.i_wb_rd_addr    = rd;
      bus.i_wb_rd_wen     = wen;
      bus.i_wb_funct3     = f3;
      bus.i_wb_alu_result = alu;
      bus.i_wb_pc_plus4   = pc4;
   endtask

   task automatic non_load(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                           input logic wen, input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [31:0] exp_data);
      logic exp_wen;
      exp_wen = wen && (rd != 5'd0);
      drive(sel, rd, wen, 3'd0, alu, pc4);
      if (exp_wen) exp_q.push_back({rd, exp_data});
      tick();
      bus.i_wb_valid = 1'b0;
      check({tag, "_wen"}, {31'd0, bus.o_regfile_rd_wen}, {31'd0, exp_wen});
      check({tag, "_addr"}, {27'd0, bus.o_regfile_rd_addr}, {27'd0, rd});
   endtask

   task automatic load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp_data);
      drive(2'd1, rd, 1'b1, f3, {30'h0000_0400, off}, 32'h0);
      tick();
      bus.i_wb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check({tag, "_wait_ready"}, {31'd0, bus.o_wb_ready}, 32'd0);
         check({tag, "_wait_wen"}, {31'd0, bus.o_regfile_rd_wen}, 32'd0);
         tick();
      end
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = rdata;
      exp_q.push_back({rd, exp_data});
      tick();
      bus.i_dmem_rvalid = 1'b0;
      check({tag, "_wen"}, {31'd0, bus.o_regfile_rd_wen}, 32'd1);
      check({tag, "_data"}, bus.o_regfile_rd_data, exp_data);
      check({tag, "_ready_after"}, {31'd0, bus.o_wb_ready}, 32'd1);
   endtask

   task automatic misaligned(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] held_data);
      drive(2'd1, 5'd9, 1'b1, f3, alu, 32'h0);
      tick();
      bus.i_wb_valid = 1'b0;
      check({tag, "_pulse"}, {31'd0, bus.o_wb_misalign}, 32'd1);
      check({tag, "_wen"}, {31'd0, bus.o_regfile_rd_wen}, 32'd0);
      check({tag, "_ready"}, {31'd0, bus.o_wb_ready}, 32'd1);
      check({tag, "_hold"}, bus.o_regfile_rd_data, held_data);
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = 32'hBAD0_BAD0;
      tick();
      bus.i_dmem_rvalid = 1'b0;
      check({tag, "_pulse_end"}, {31'd0, bus.o_wb_misalign}, 32'd0);
      check({tag, "_spurious_wen"}, {31'd0, bus.o_regfile_rd_wen}, 32'd0);
   endtask

   initial begin
      bus.i_wb_valid      = 1'b0;
      bus.i_wb_sel        = 2'd0;
      bus.i_wb_rd_addr    = 5'd0;
      bus.i_wb_rd_wen     = 1'b0;
      bus.i_wb_funct3     = 3'd0;
      bus.i_wb_alu_result = 32'h0;
      bus.i_wb_pc_plus4   = 32'h0;
      bus.i_dmem_rvalid   = 1'b0;
      bus.i_dmem_rdata    = 32'h0;

      tick();
      tick();
      check("rst_ready", {31'd0, bus.o_wb_ready}, 32'd1);
      check("rst_wen", {31'd0, bus.o_regfile_rd_wen}, 32'd0);
      check("rst_data", bus.o_regfile_rd_data, 32'd0);
      check("rst_addr", {27'd0, bus.o_regfile_rd_addr}, 32'd0);
      check("rst_misalign", {31'd0, bus.o_wb_misalign}, 32'd0);
      i_rst = 1'b0;
      tick();

      // Reset in the middle of a load wait abandons the load.
      drive(2'd1, 5'd7, 1'b1, 3'b010, 32'h0000_1000, 32'h0);
      tick();
      bus.i_wb_valid = 1'b0;
      check("t1_in_wait_ready", {31'd0, bus.o_wb_ready}, 32'd0);
      #3;
      i_rst = 1'b1;
      #1;
      check("t1_rst_ready", {31'd0, bus.o_wb_ready}, 32'd1);
      check("t1_rst_data", bus.o_regfile_rd_data, 32'd0);
      tick();
      i_rst = 1'b0;
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = 32'h5555_AAAA;
      tick();
      bus.i_dmem_rvalid = 1'b0;
      check("t1_no_write", {31'd0, bus.o_regfile_rd_wen}, 32'd0);
      tick();

      // ALU, PC+4, reserved select and x0 suppression.
      non_load("alu_rd5", 2'd0, 5'd5, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_5678);
      check("alu_rd5_data", bus.o_regfile_rd_data, 32'h1234_5678);
      non_load("alu_rd0", 2'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D);
      non_load("alu_nowen", 2'd0, 5'd6, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_0011);
      non_load("pc4", 2'd2, 5'd1, 1'b1, 32'h0000_0123, 32'h0000_2004, 32'h0000_2004);
      non_load("rsvd", 2'd3, 5'd31, 1'b1, 32'h0BAD_C0DE, 32'h0000_3000, 32'h0BAD_C0DE);

      // Back-to-back accepts with valid held high.
      for (int i = 1; i <= 3; i++) begin
         drive(2'd0, i[4:0], 1'b1, 3'd0, 32'hA000_0000 + i, 32'h0);
         exp_q.push_back({i[4:0], 32'hA000_0000 + i});
         tick();
         check("b2b_ready", {31'd0, bus.o_wb_ready}, 32'd1);
         check("b2b_wen", {31'd0, bus.o_regfile_rd_wen}, 32'd1);
         check("b2b_addr", {27'd0, bus.o_regfile_rd_addr}, i);
      end
      bus.i_wb_valid = 1'b0;
      tick();

      // Aligned loads from word 0x80FF7F01.
      load("lb3",  3'b000, 2'd3, 5'd10, 32'h80FF_7F01, 32'hFFFF_FF80);
      load("lbu2", 3'b100, 2'd2, 5'd11, 32'h80FF_7F01, 32'h0000_00FF);
      load("lh0",  3'b001, 2'd0, 5'd12, 32'h80FF_7F01, 32'h0000_7F01);
      load("lhu2", 3'b101, 2'd2, 5'd13, 32'h80FF_7F01, 32'h0000_80FF);
      load("lw",   3'b010, 2'd0, 5'd14, 32'h80FF_7F01, 32'h80FF_7F01);
      load("lh2",  3'b001, 2'd2, 5'd15, 32'h80FF_7F01, 32'hFFFF_80FF);
      load("lb1",  3'b000, 2'd1, 5'd16, 32'h80FF_7F01, 32'h0000_007F);
      load("f3_6", 3'b110, 2'd0, 5'd17, 32'h1357_9BDF, 32'h1357_9BDF);

      // Misaligned loads: no write, data held, spurious response ignored.
      misaligned("mis_lw", 3'b010, 32'h0000_1002, 32'h1357_9BDF);
      misaligned("mis_lh", 3'b001, 32'h0000_1001, 32'h1357_9BDF);

`ifdef RISCV_WB_RETIRE_CNT_EN
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("cnt_reset", retire_cnt[31:0], 32'd0);
      non_load("cnt_alu0", 2'd0, 5'd3, 1'b1, 32'h1, 32'h0, 32'h1);
      non_load("cnt_alu1", 2'd0, 5'd4, 1'b1, 32'h2, 32'h0, 32'h2);
      load("cnt_ld", 3'b010, 2'd0, 5'd8, 32'h7777_0000, 32'h7777_0000);
      misaligned("cnt_mis", 3'b010, 32'h0000_1002, 32'h7777_0000);
      check("cnt_value", retire_cnt[31:0], 32'd4);
`endif

      tick();
      check("sb_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
